// File: rtl/ofifo.sv
// Output FIFO bank: one circular buffer per mac_col column, released as aligned rows.
// Optional sticky overflow flag is built when OFIFO_OVERFLOW_EN is defined.
module ofifo #(
  parameter int col     = 8,
  parameter int bw_psum = 22,
  parameter int depth   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_overflow
);

  localparam int AW = $clog2(depth);

  logic [AW:0]          r_wr_ptr [col];
  logic [AW:0]          r_rd_ptr [col];
  logic [bw_psum-1:0]   r_mem    [col][depth];

  logic [col-1:0]         w_empty;
  logic [col-1:0]         w_full;
  logic [col-1:0]         w_wr_acc;
  logic                   w_rd_acc;
  logic [col*bw_psum-1:0] w_head;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    w_head  = '0;
    for (int c = 0; c < col; c++) begin
      w_empty[c] = (r_wr_ptr[c] == r_rd_ptr[c]);
      w_full[c]  = (r_wr_ptr[c][AW-1:0] == r_rd_ptr[c][AW-1:0]) &&
                   (r_wr_ptr[c][AW] != r_rd_ptr[c][AW]);
      w_head[c*bw_psum +: bw_psum] = r_mem[c][r_rd_ptr[c][AW-1:0]];
    end
  end

  assign o_ready  = ~|w_empty;
  assign o_full   = |w_full;
  assign w_rd_acc = rd & o_ready;
  // A full column still takes a write when the same cycle pops a row.
  assign w_wr_acc = wr & (~w_full | {col{w_rd_acc}});

  // NOTE: storage carries no reset; its contents are unobservable until a pointer advances.
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (w_wr_acc[c]) begin
        r_mem[c][r_wr_ptr[c][AW-1:0]] <= in[c*bw_psum +: bw_psum];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all columns update from the same snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < col; c++) begin
        if (w_wr_acc[c]) r_wr_ptr[c] <= r_wr_ptr[c] + (AW+1)'(1);
        if (w_rd_acc)    r_rd_ptr[c] <= r_rd_ptr[c] + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out     <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= w_rd_acc;
      if (w_rd_acc) out <= w_head;
    end
  end

`ifdef OFIFO_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (|(wr & ~w_wr_acc)) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_overflow = r_overflow;
`else
  assign o_overflow = 1'b0;
`endif

endmodule
